addsub_slice_sequencer: RTL and testbench

//  Multi-cycle controller that time-shares one narrow ripple-carry add/sub slice to compute a

---
 rtl/calc_pkg.sv | 30 +++
 rtl/addsub_slice.sv | 29 ++
 rtl/addsub_slice_sequencer.sv | 122 ++++++++++++
 tb/tb_addsub_slice_sequencer.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator add/sub sequencer.
// Holds the sequencer state encoding, operation codes and the result validity rule.
package calc_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } seq_state_t;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   localparam int DEFAULT_SLICE = 4;

   // Unsigned: a subtract is valid without borrow (carry=1), an add without carry-out.
   // Signed: overflow when the carry into and out of the sign bit disagree.
   function automatic logic seq_valid(input logic sub, input logic sgn,
                                      input logic co, input logic cmsb);
      logic v;
      if (sgn)
         v = ~(co ^ cmsb);
      else if (sub == OP_SUB)
         v = co;
      else
         v = ~co;
      return v;
   endfunction

endpackage

// File: rtl/addsub_slice.sv
// SLICE-bit combinational ripple-carry adder slice.
// Reports both the carry-out and the carry into the slice MSB for signed overflow detection.
module addsub_slice #(
   parameter int SLICE = 4
) (
   input  logic [SLICE-1:0] a,
   input  logic [SLICE-1:0] b,
   input  logic             cin,
   output logic [SLICE-1:0] sum,
   output logic             cout,
   output logic             c_msb
);

   logic [SLICE:0] c;

   always_comb begin
      c      = '0;
      sum    = '0;
      c[0]   = cin;
      for (int i = 0; i < SLICE; i++) begin
         sum[i]   = a[i] ^ b[i] ^ c[i];
         c[i+1]   = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
      end
   end

   assign cout  = c[SLICE];
   assign c_msb = c[SLICE-1];

endmodule

// File: rtl/addsub_slice_sequencer.sv
// Time-shares one add/sub slice to compute a WIDTH-bit A+B or A-B, LSB slice first.
// Optional sticky error flag (ports clrErr/errSticky) enabled by defining SEQ_STICKY_ERR_EN.
module addsub_slice_sequencer
   import calc_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int SLICE = DEFAULT_SLICE
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             addSub,
   input  logic             isSigned,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
`ifdef SEQ_STICKY_ERR_EN
   input  logic             clrErr,
   output logic             errSticky,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             valid
);

   localparam int NSLICE = WIDTH / SLICE;
   localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   seq_state_t       state;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic             op_sub;
   logic             op_signed;
   logic             carry;
   logic [IDXW-1:0]  idx;

   logic [SLICE-1:0] slice_a;
   logic [SLICE-1:0] slice_b;
   logic [SLICE-1:0] slice_sum;
   logic             slice_cout;
   logic             slice_cmsb;
   logic             last;

   assign slice_a = a_reg[int'(idx) * SLICE +: SLICE];
   assign slice_b = b_reg[int'(idx) * SLICE +: SLICE];
   assign last    = (idx == IDXW'(NSLICE - 1));

   addsub_slice #(.SLICE(SLICE)) u_slice (
      .a     (slice_a),
      .b     (slice_b),
      .cin   (carry),
      .sum   (slice_sum),
      .cout  (slice_cout),
      .c_msb (slice_cmsb)
   );

   // B is stored pre-inverted and the carry seeded with addSub, so subtraction is A + ~B + 1.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         result    <= '0;
         valid     <= 1'b0;
         carry     <= 1'b0;
         idx       <= '0;
         a_reg     <= '0;
         b_reg     <= '0;
         op_sub    <= OP_ADD;
         op_signed <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  a_reg     <= a;
                  b_reg     <= b ^ {WIDTH{addSub}};
                  op_sub    <= addSub;
                  op_signed <= isSigned;
                  carry     <= addSub;
                  idx       <= '0;
                  state     <= RUN;
                  busy      <= 1'b1;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               result[int'(idx) * SLICE +: SLICE] <= slice_sum;
               carry <= slice_cout;
               if (last) begin
                  valid <= seq_valid(op_sub, op_signed, slice_cout, slice_cmsb);
                  idx   <= '0;
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

`ifdef SEQ_STICKY_ERR_EN
   // Set takes priority over clear so an error in the clearing cycle is not lost.
   always_ff @(posedge clk) begin
      if (rst)
         errSticky <= 1'b0;
      else if (done && !valid)
         errSticky <= 1'b1;
      else if (clrErr)
         errSticky <= 1'b0;
   end
`endif

endmodule

// File: tb/tb_addsub_slice_sequencer.sv
// Scoreboard bench for addsub_slice_sequencer (WIDTH=8, SLICE=4).
// Define SEQ_STICKY_ERR_EN to also exercise the sticky error flag.
module tb_addsub_slice_sequencer;

   logic       clk;
   logic       rst;
   logic       start;
   logic       addSub;
   logic       isSigned;
   logic [7:0] a;
   logic [7:0] b;
   logic       busy;
   logic       done;
   logic [7:0] result;
   logic       valid;
`ifdef SEQ_STICKY_ERR_EN
   logic       clrErr;
   logic       errSticky;
`endif

   int checks;
   int failures;
   int doneCount;
   int expectedDone;
   logic [8:0] expQ[$];

   addsub_slice_sequencer #(.WIDTH(8), .SLICE(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .addSub   (addSub),
      .isSigned (isSigned),
      .a        (a),
      .b        (b),
`ifdef SEQ_STICKY_ERR_EN
      .clrErr   (clrErr),
      .errSticky(errSticky),
`endif
      .busy     (busy),
      .done     (done),
      .result   (result),
      .valid    (valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
      end
   endtask

   // Monitor: pops the scoreboard on every done pulse.
   always @(negedge clk) begin
      logic [8:0] e;
      if (!rst) begin
         checkOutput("done_busy_exclusive", {31'd0, done & busy}, 32'd0);
         if (done === 1'b1) begin
            doneCount++;
            if (expQ.size() == 0) begin
               checkOutput("unexpected_done", 32'd1, 32'd0);
            end else begin
               e = expQ.pop_front();
               checkOutput("result", {24'd0, result}, {24'd0, e[7:0]});
               checkOutput("valid", {31'd0, valid}, {31'd0, e[8]});
            end
         end
      end
   end

   // Issues one op at posedge+#1 and checks the two-slice latency on the way.
   task automatic applyStimulus(input logic sub, input logic sgn, input logic [7:0] av,
                                input logic [7:0] bv, input logic [7:0] er, input logic ev);
      start = 1'b1; addSub = sub; isSigned = sgn; a = av; b = bv;
      expQ.push_back({ev, er});
      expectedDone++;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      checkOutput("lat_busy_e1", {31'd0, busy}, 32'd1);
      checkOutput("lat_done_e1", {31'd0, done}, 32'd0);
      @(posedge clk); #1;
      checkOutput("lat_done_e2", {31'd0, done}, 32'd1);
      checkOutput("lat_busy_e2", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      checks = 0; failures = 0; doneCount = 0; expectedDone = 0;
      rst = 1'b1; start = 1'b0; addSub = 1'b0; isSigned = 1'b0; a = '0; b = '0;
`ifdef SEQ_STICKY_ERR_EN
      clrErr = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_busy", {31'd0, busy}, 32'd0);
      checkOutput("reset_done", {31'd0, done}, 32'd0);
      checkOutput("reset_result", {24'd0, result}, 32'd0);
      checkOutput("reset_valid", {31'd0, valid}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      applyStimulus(1'b0, 1'b0, 8'd200, 8'd100, 8'h2C, 1'b0);
      applyStimulus(1'b1, 1'b0, 8'd100, 8'd50,  8'd50,  1'b1);
      applyStimulus(1'b1, 1'b0, 8'd50,  8'd100, 8'hCE, 1'b0);
      applyStimulus(1'b0, 1'b1, 8'h7F,  8'h01,  8'h80, 1'b0);
      applyStimulus(1'b1, 1'b1, 8'hFE,  8'h01,  8'hFD, 1'b1);
      applyStimulus(1'b0, 1'b0, 8'hFF,  8'h00,  8'hFF, 1'b1);
      applyStimulus(1'b1, 1'b1, 8'h80,  8'h01,  8'h7F, 1'b0);
      applyStimulus(1'b0, 1'b0, 8'h0F,  8'h01,  8'h10, 1'b1);

      // start pulsed mid-RUN with other operands must be ignored
      start = 1'b1; addSub = 1'b0; isSigned = 1'b0; a = 8'h0F; b = 8'h01;
      expQ.push_back({1'b1, 8'h10});
      expectedDone++;
      @(posedge clk); #1;
      start = 1'b1; addSub = 1'b1; a = 8'hFF; b = 8'hFF;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      checkOutput("ignored_start_result", {24'd0, result}, 32'h10);
      checkOutput("ignored_start_idle", {31'd0, busy}, 32'd0);

      // reset in the first RUN cycle discards the op
      start = 1'b1; addSub = 1'b0; isSigned = 1'b0; a = 8'd200; b = 8'd100;
      @(posedge clk); #1;
      start = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checkOutput("midrun_rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("midrun_rst_done", {31'd0, done}, 32'd0);
      checkOutput("midrun_rst_result", {24'd0, result}, 32'd0);
      checkOutput("midrun_rst_valid", {31'd0, valid}, 32'd0);
      repeat (5) @(posedge clk);
      #1;

      // back-to-back: start held high through DONE
      start = 1'b1; addSub = 1'b0; isSigned = 1'b0; a = 8'd200; b = 8'd100;
      expQ.push_back({1'b0, 8'h2C});
      expQ.push_back({1'b1, 8'hFD});
      expectedDone += 2;
      @(posedge clk); #1;
      addSub = 1'b1; isSigned = 1'b1; a = 8'hFE; b = 8'h01;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checkOutput("b2b_done", {31'd0, done}, 32'd1);
      @(posedge clk); #1;
      start = 1'b0;
      checkOutput("b2b_busy_again", {31'd0, busy}, 32'd1);
      repeat (3) @(posedge clk);
      #1;

`ifdef SEQ_STICKY_ERR_EN
      checkOutput("sticky_set", {31'd0, errSticky}, 32'd1);
      clrErr = 1'b1;
      @(posedge clk); #1;
      clrErr = 1'b0;
      checkOutput("sticky_clear", {31'd0, errSticky}, 32'd0);
`endif

      for (int k = 0; k < 20 && expQ.size() != 0; k++) @(posedge clk);
      #1;
      checkOutput("scoreboard_drained", expQ.size(), 32'd0);
      checkOutput("done_count", doneCount, expectedDone);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
